bcd_counter: RTL and testbench

BCD_COUNTER -- requirements
Module: bcd_counter

---
 rtl/bcd_counter_pkg.sv | 26 ++
 rtl/bcd_digit.sv | 53 +++++
 rtl/bcd_counter.sv | 93 +++++++++
 tb/tb_bcd_counter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_counter_pkg.sv
// ============================================================================
// bcd_counter_pkg : shared BCD digit bounds, terminal values and helpers
// Revision 1.0
// ============================================================================
`default_nettype none

package bcd_counter_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t DIGIT_MIN   = 4'd0;
  localparam bcd_digit_t DIGIT_MAX   = 4'd9;
  localparam logic [7:0] TC_UP_VAL   = 8'h99;
  localparam logic [7:0] TC_DOWN_VAL = 8'h00;

  function automatic logic is_bcd_digit(input bcd_digit_t d);
    return (d <= DIGIT_MAX);
  endfunction

  function automatic logic is_bcd_byte(input logic [7:0] b);
    return is_bcd_digit(b[7:4]) && is_bcd_digit(b[3:0]);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit.sv
// ============================================================================
// bcd_digit : one decade (0-9) up/down counter with load, carry-in/out
// Revision 1.0
// ============================================================================
`default_nettype none

module bcd_digit
  import bcd_counter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic       up_i,
  input  logic       load_i,
  input  bcd_digit_t load_val_i,
  input  logic       cin_i,
  output logic       cout_o,
  output bcd_digit_t digit_o
);

  bcd_digit_t digit_q;
  bcd_digit_t digit_d;
  logic       at_edge;

  // Edge value is 9 when counting up and 0 when counting down.
  assign at_edge = up_i ? (digit_q == DIGIT_MAX) : (digit_q == DIGIT_MIN);
  assign cout_o  = cin_i & at_edge;
  assign digit_o = digit_q;

  always_comb begin
    digit_d = digit_q;
    if (load_i) begin
      digit_d = load_val_i;
    end else if (en_i && cin_i) begin
      if (up_i) begin
        digit_d = at_edge ? DIGIT_MIN : digit_q + 4'd1;
      end else begin
        digit_d = at_edge ? DIGIT_MAX : digit_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      digit_q <= DIGIT_MIN;
    end else begin
      digit_q <= digit_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/bcd_counter.sv
// ============================================================================
// bcd_counter : two-digit BCD up/down counter, wrap or saturate at 00/99
// Revision 1.0
// ============================================================================
`default_nettype none

module bcd_counter
  import bcd_counter_pkg::*;
#(
  parameter int WRAP = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       up,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] q,
  output logic       tc,
  output logic       load_err
);

  logic       load_ok;
  logic       digit_load;
  logic       step;
  logic       at_term;
  logic       ones_cout;
  logic       tens_cout;
  bcd_digit_t ones;
  bcd_digit_t tens;
  logic       tc_q;
  logic       tc_d;
  logic       load_err_q;
  logic       load_err_d;

  assign load_ok    = is_bcd_byte(load_val);
  assign digit_load = load & load_ok;

  // Both digits sitting at their edge for the current direction means 99 (up) or 00 (down).
  assign at_term = tens_cout;

  generate
    if (WRAP != 0) begin : g_wrap
      assign step = en & ~load;
    end else begin : g_sat
      assign step = en & ~load & ~at_term;
    end
  endgenerate

  bcd_digit u_ones (
    .clk        (clk),
    .rst        (rst),
    .en_i       (step),
    .up_i       (up),
    .load_i     (digit_load),
    .load_val_i (load_val[3:0]),
    .cin_i      (1'b1),
    .cout_o     (ones_cout),
    .digit_o    (ones)
  );

  bcd_digit u_tens (
    .clk        (clk),
    .rst        (rst),
    .en_i       (step),
    .up_i       (up),
    .load_i     (digit_load),
    .load_val_i (load_val[7:4]),
    .cin_i      (ones_cout),
    .cout_o     (tens_cout),
    .digit_o    (tens)
  );

  assign tc_d       = en & ~load & at_term;
  assign load_err_d = load & ~load_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      tc_q       <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      tc_q       <= tc_d;
      load_err_q <= load_err_d;
    end
  end

  assign q        = {tens, ones};
  assign tc       = tc_q;
  assign load_err = load_err_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_counter.sv
// ============================================================================
// tb_bcd_counter : directed vector table plus wrap/saturate sweeps, WRAP=1 and WRAP=0
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_bcd_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] q1, q0;
  logic       tc1, tc0;
  logic       err1, err0;

  int n_checks = 0;
  int n_fail   = 0;

  bcd_counter #(.WRAP(1)) u_dut_wrap (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .q(q1), .tc(tc1), .load_err(err1)
  );

  bcd_counter #(.WRAP(0)) u_dut_sat (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .q(q0), .tc(tc0), .load_err(err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       load;
    logic [7:0] lv;
    logic       en;
    logic       up;
    logic [7:0] q1;
    logic       tc1;
    logic       e1;
    logic [7:0] q0;
    logic       tc0;
    logic       e0;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic ld, input logic [7:0] lv, input logic e,
                     input logic u, input logic [7:0] eq1, input logic etc1, input logic ee1,
                     input logic [7:0] eq0, input logic etc0, input logic ee0);
    vec_t v;
    v.rst = r; v.load = ld; v.lv = lv; v.en = e; v.up = u;
    v.q1 = eq1; v.tc1 = etc1; v.e1 = ee1; v.q0 = eq0; v.tc0 = etc0; v.e0 = ee0;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_nibbles(input string name, input logic [7:0] act);
    logic ok;
    ok = (act[7:4] <= 4'd9) && (act[3:0] <= 4'd9);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s nibble range: got %h expected both nibbles <= 9", name, act);
    end
  endtask

  task automatic drive(input logic r, input logic ld, input logic [7:0] lv, input logic e,
                       input logic u);
    rst = r; load = ld; load_val = lv; en = e; up = u;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] to_bcd(input int n);
    logic [3:0] t;
    logic [3:0] o;
    t = 4'(n / 10);
    o = 4'(n % 10);
    return {t, o};
  endfunction

  initial begin
    int m1, m0, p1, p0;
    rst = 1'b1; load = 1'b0; load_val = 8'h00; en = 1'b0; up = 1'b1;

    //   rst ld  lv     en  up   q1    tc e   q0    tc e
    add(1, 0, 8'h00, 0, 1, 8'h00, 0, 0, 8'h00, 0, 0);
    add(0, 1, 8'h08, 1, 1, 8'h08, 0, 0, 8'h08, 0, 0);
    add(0, 0, 8'h00, 1, 1, 8'h09, 0, 0, 8'h09, 0, 0);
    add(0, 0, 8'h00, 1, 1, 8'h10, 0, 0, 8'h10, 0, 0);
    add(0, 0, 8'h00, 1, 1, 8'h11, 0, 0, 8'h11, 0, 0);
    add(0, 1, 8'h98, 0, 1, 8'h98, 0, 0, 8'h98, 0, 0);
    add(0, 0, 8'h00, 1, 1, 8'h99, 0, 0, 8'h99, 0, 0);
    add(0, 1, 8'h99, 1, 1, 8'h99, 0, 0, 8'h99, 0, 0);
    add(0, 0, 8'h00, 1, 1, 8'h00, 1, 0, 8'h99, 1, 0);
    add(0, 0, 8'h00, 1, 1, 8'h01, 0, 0, 8'h99, 1, 0);
    add(0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 8'h98, 0, 0);
    add(0, 1, 8'h01, 0, 0, 8'h01, 0, 0, 8'h01, 0, 0);
    add(0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    add(0, 0, 8'h00, 1, 0, 8'h99, 1, 0, 8'h00, 1, 0);
    add(0, 0, 8'h00, 1, 0, 8'h98, 0, 0, 8'h00, 1, 0);
    add(0, 1, 8'h42, 0, 1, 8'h42, 0, 0, 8'h42, 0, 0);
    add(0, 1, 8'h3A, 1, 1, 8'h42, 0, 1, 8'h42, 0, 1);
    add(0, 1, 8'hA5, 0, 1, 8'h42, 0, 1, 8'h42, 0, 1);
    add(0, 0, 8'h00, 0, 1, 8'h42, 0, 0, 8'h42, 0, 0);
    add(0, 1, 8'h37, 0, 1, 8'h37, 0, 0, 8'h37, 0, 0);
    add(1, 1, 8'h55, 1, 1, 8'h00, 0, 0, 8'h00, 0, 0);
    add(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    add(0, 0, 8'h00, 1, 1, 8'h01, 0, 0, 8'h01, 0, 0);
    add(0, 1, 8'h9F, 1, 0, 8'h01, 0, 1, 8'h01, 0, 1);
    add(0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].load, vecs[i].lv, vecs[i].en, vecs[i].up);
      chk($sformatf("vec%0d q wrap", i), q1, vecs[i].q1);
      chk($sformatf("vec%0d tc wrap", i), {7'd0, tc1}, {7'd0, vecs[i].tc1});
      chk($sformatf("vec%0d load_err wrap", i), {7'd0, err1}, {7'd0, vecs[i].e1});
      chk($sformatf("vec%0d q sat", i), q0, vecs[i].q0);
      chk($sformatf("vec%0d tc sat", i), {7'd0, tc0}, {7'd0, vecs[i].tc0});
      chk($sformatf("vec%0d load_err sat", i), {7'd0, err0}, {7'd0, vecs[i].e0});
      chk_nibbles($sformatf("vec%0d wrap", i), q1);
      chk_nibbles($sformatf("vec%0d sat", i), q0);
    end

    // Full up sweep through two wraps, then full down sweep, against an integer model.
    drive(1, 0, 8'h00, 0, 1);
    m1 = 0; m0 = 0;
    for (int k = 0; k < 205; k++) begin
      drive(0, 0, 8'h00, 1, 1);
      p1 = m1; p0 = m0;
      m1 = (m1 + 1) % 100;
      m0 = (m0 == 99) ? 99 : m0 + 1;
      chk($sformatf("up%0d q wrap", k), q1, to_bcd(m1));
      chk($sformatf("up%0d tc wrap", k), {7'd0, tc1}, {7'd0, p1 == 99});
      chk($sformatf("up%0d q sat", k), q0, to_bcd(m0));
      chk($sformatf("up%0d tc sat", k), {7'd0, tc0}, {7'd0, p0 == 99});
      chk_nibbles($sformatf("up%0d wrap", k), q1);
      chk_nibbles($sformatf("up%0d sat", k), q0);
    end
    for (int k = 0; k < 205; k++) begin
      drive(0, 0, 8'h00, 1, 0);
      p1 = m1; p0 = m0;
      m1 = (m1 + 99) % 100;
      m0 = (m0 == 0) ? 0 : m0 - 1;
      chk($sformatf("dn%0d q wrap", k), q1, to_bcd(m1));
      chk($sformatf("dn%0d tc wrap", k), {7'd0, tc1}, {7'd0, p1 == 0});
      chk($sformatf("dn%0d q sat", k), q0, to_bcd(m0));
      chk($sformatf("dn%0d tc sat", k), {7'd0, tc0}, {7'd0, p0 == 0});
      chk_nibbles($sformatf("dn%0d wrap", k), q1);
      chk_nibbles($sformatf("dn%0d sat", k), q0);
    end

    // Reset in the middle of counting, then resume from 00.
    drive(0, 1, 8'h57, 0, 1);
    drive(0, 0, 8'h00, 1, 1);
    chk("mid q before rst", q1, 8'h58);
    drive(1, 0, 8'h00, 1, 1);
    chk("mid rst q", q1, 8'h00);
    chk("mid rst q sat", q0, 8'h00);
    drive(0, 0, 8'h00, 1, 1);
    chk("resume q", q1, 8'h01);
    chk("resume tc", {7'd0, tc1}, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
